// File: rtl/registra_especial_multi.sv
// registra_especial_multi
// Registers one "special shot": up to N_TIROS shots, one per direction enabled
// in a mask, all at the same ship position. The shots go into free slots of an
// external shot memory. The block scans directions in ascending order and
// memory slots in ascending order. It writes a shot only into a slot whose
// loaded flag is clear. It stops when every enabled direction has been placed
// or when the last slot has been examined.
//
// Ports
//   clock, reset            clock (rising edge), synchronous active-high reset
//   registra_tiro_especial  start request, accepted only while idle (ESPERA)
//   mascara_direcoes        direction enable mask, latched at start
//   posicao_nave            ship position, latched at start
//   loaded_tiro             loaded flag of the slot at endereco_tiro (async read)
//   endereco_tiro           slot pointer
//   dado_posicao            position to write
//   dado_opcode             direction index to write
//   enable_mem_tiro         memory write strobe
//   enable_load_tiro        sets the loaded flag of the addressed slot
//   especial_registrado     one-cycle done pulse
//   especial_incompleto     with the done pulse: some enabled direction was not placed
//   tiros_registrados       number of shots written by the current/last operation
//   ocupado                 busy (every state except ESPERA)
//   db_estado               state code for debug
//
// state        | meaning
// -------------+-----------------------------------------------------------
// INICIAL  (0) | post-reset, moves to ESPERA
// ESPERA   (1) | idle, waits for start and latches mask/position
// ZERA     (2) | clears slot pointer, direction index and shot count
// PROCURA_DIR(3)| finds the next enabled direction, or finishes when none remain
// VERIFICA (4) | checks whether the current slot is occupied
// SALVA    (5) | writes the shot (dir, position) into the current slot
// AVANCA_SLOT(6)| moves to the next slot, or finishes at the last slot
// SINALIZA (7) | done pulse plus the incomplete flag

module registra_especial_multi #(
    parameter int N_TIROS  = 4,
    parameter int PROF_MEM = 16,
    parameter int W_POS    = 4,
    parameter int W_OP     = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         registra_tiro_especial,
    input  logic [N_TIROS-1:0]           mascara_direcoes,
    input  logic [W_POS-1:0]             posicao_nave,
    input  logic                         loaded_tiro,
    output logic [$clog2(PROF_MEM)-1:0]  endereco_tiro,
    output logic [W_POS-1:0]             dado_posicao,
    output logic [W_OP-1:0]              dado_opcode,
    output logic                         enable_mem_tiro,
    output logic                         enable_load_tiro,
    output logic                         especial_registrado,
    output logic                         especial_incompleto,
    output logic [$clog2(N_TIROS+1)-1:0] tiros_registrados,
    output logic                         ocupado,
    output logic [3:0]                   db_estado
);

    localparam int W_ADR = $clog2(PROF_MEM);
    localparam int W_CNT = $clog2(N_TIROS + 1);

    // A 4-bit state register leaves codes 8..15 unused; they decode as F and recover.
    localparam logic [3:0] ST_INICIAL     = 4'd0;
    localparam logic [3:0] ST_ESPERA      = 4'd1;
    localparam logic [3:0] ST_ZERA        = 4'd2;
    localparam logic [3:0] ST_PROCURA_DIR = 4'd3;
    localparam logic [3:0] ST_VERIFICA    = 4'd4;
    localparam logic [3:0] ST_SALVA       = 4'd5;
    localparam logic [3:0] ST_AVANCA_SLOT = 4'd6;
    localparam logic [3:0] ST_SINALIZA    = 4'd7;

    logic [3:0]         estado_q,  estado_d;
    logic [N_TIROS-1:0] mascara_q, mascara_d;
    logic [W_POS-1:0]   posicao_q, posicao_d;
    logic [W_ADR-1:0]   slot_q,    slot_d;
    logic [W_CNT-1:0]   dir_q,     dir_d;
    logic [W_CNT-1:0]   cont_q,    cont_d;

    logic dir_fim;
    logic mask_bit;
    logic resto;

    // dir_q ranges 0..N_TIROS. The mask is selected by comparison instead of
    // a direct index, so dir_q == N_TIROS never addresses past the mask.
    always_comb begin
        mask_bit = 1'b0;
        resto    = 1'b0;
        for (int i = 0; i < N_TIROS; i++) begin
            if (i == int'(dir_q)) begin
                mask_bit = mascara_q[i];
            end
            if ((i >= int'(dir_q)) && mascara_q[i]) begin
                resto = 1'b1;
            end
        end
    end

    assign dir_fim = (dir_q == W_CNT'(N_TIROS));

    always_comb begin
        estado_d  = estado_q;
        mascara_d = mascara_q;
        posicao_d = posicao_q;
        slot_d    = slot_q;
        dir_d     = dir_q;
        cont_d    = cont_q;
        case (estado_q)
            ST_INICIAL: begin
                estado_d = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (registra_tiro_especial) begin
                    mascara_d = mascara_direcoes;
                    posicao_d = posicao_nave;
                    estado_d  = ST_ZERA;
                end
            end
            ST_ZERA: begin
                slot_d   = '0;
                dir_d    = '0;
                cont_d   = '0;
                estado_d = ST_PROCURA_DIR;
            end
            ST_PROCURA_DIR: begin
                if (dir_fim) begin
                    estado_d = ST_SINALIZA;
                end else if (!mask_bit) begin
                    dir_d = dir_q + W_CNT'(1);
                end else begin
                    estado_d = ST_VERIFICA;
                end
            end
            ST_VERIFICA: begin
                estado_d = loaded_tiro ? ST_AVANCA_SLOT : ST_SALVA;
            end
            ST_SALVA: begin
                dir_d    = dir_q + W_CNT'(1);
                cont_d   = cont_q + W_CNT'(1);
                estado_d = ST_AVANCA_SLOT;
            end
            ST_AVANCA_SLOT: begin
                // Last slot ends the operation; the pointer never wraps.
                if (slot_q == W_ADR'(PROF_MEM - 1)) begin
                    estado_d = ST_SINALIZA;
                end else begin
                    slot_d   = slot_q + W_ADR'(1);
                    estado_d = ST_PROCURA_DIR;
                end
            end
            ST_SINALIZA: begin
                estado_d = ST_ESPERA;
            end
            default: begin
                estado_d = ST_INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= ST_INICIAL;
            mascara_q <= '0;
            posicao_q <= '0;
            slot_q    <= '0;
            dir_q     <= '0;
            cont_q    <= '0;
        end else begin
            estado_q  <= estado_d;
            mascara_q <= mascara_d;
            posicao_q <= posicao_d;
            slot_q    <= slot_d;
            dir_q     <= dir_d;
            cont_q    <= cont_d;
        end
    end

    // Strobes depend only on the state. Data comes straight from registers,
    // so it stays stable for the whole SALVA cycle.
    assign enable_mem_tiro     = (estado_q == ST_SALVA);
    assign enable_load_tiro    = (estado_q == ST_SALVA);
    assign especial_registrado = (estado_q == ST_SINALIZA);
    assign especial_incompleto = (estado_q == ST_SINALIZA) && resto;
    assign ocupado             = (estado_q != ST_ESPERA);
    assign db_estado           = (estado_q <= ST_SINALIZA) ? estado_q : 4'hF;
    assign endereco_tiro       = slot_q;
    assign dado_posicao        = posicao_q;
    assign dado_opcode         = W_OP'(dir_q);
    assign tiros_registrados   = cont_q;

endmodule

// File: tb/tb_registra_especial_multi.sv
// Directed self-checking bench for registra_especial_multi (default parameters).
// The bench models the shot memory's loaded flags and logs every write strobe.
module tb_registra_especial_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic        registra_tiro_especial;
    logic [3:0]  mascara_direcoes;
    logic [3:0]  posicao_nave;
    logic        loaded_tiro;
    logic [3:0]  endereco_tiro;
    logic [3:0]  dado_posicao;
    logic [2:0]  dado_opcode;
    logic        enable_mem_tiro;
    logic        enable_load_tiro;
    logic        especial_registrado;
    logic        especial_incompleto;
    logic [2:0]  tiros_registrados;
    logic        ocupado;
    logic [3:0]  db_estado;

    registra_especial_multi dut (
        .clock                  (clock),
        .reset                  (reset),
        .registra_tiro_especial (registra_tiro_especial),
        .mascara_direcoes       (mascara_direcoes),
        .posicao_nave           (posicao_nave),
        .loaded_tiro            (loaded_tiro),
        .endereco_tiro          (endereco_tiro),
        .dado_posicao           (dado_posicao),
        .dado_opcode            (dado_opcode),
        .enable_mem_tiro        (enable_mem_tiro),
        .enable_load_tiro       (enable_load_tiro),
        .especial_registrado    (especial_registrado),
        .especial_incompleto    (especial_incompleto),
        .tiros_registrados      (tiros_registrados),
        .ocupado                (ocupado),
        .db_estado              (db_estado)
    );

    always #5 clock = ~clock;

    // Shot-memory loaded flags; preset from the stimulus, set by load strobes.
    logic        preset_en = 1'b0;
    logic [15:0] preset_val = '0;
    logic [15:0] mem_ld = '0;

    always @(posedge clock) begin
        if (preset_en) mem_ld <= preset_val;
        else if (enable_load_tiro) mem_ld[endereco_tiro] <= 1'b1;
    end

    assign loaded_tiro = mem_ld[endereco_tiro];

    // Write log and done-pulse counter.
    logic [3:0] wr_slot[$];
    logic [2:0] wr_op[$];
    logic [3:0] wr_pos[$];
    logic       wr_ld[$];
    int         done_cnt = 0;

    always @(negedge clock) begin
        if (enable_mem_tiro) begin
            wr_slot.push_back(endereco_tiro);
            wr_op.push_back(dado_opcode);
            wr_pos.push_back(dado_posicao);
            wr_ld.push_back(enable_load_tiro);
        end
        if (especial_registrado) done_cnt++;
    end

    int n_assert = 0;
    int n_fail   = 0;

    int   base;
    int   done_base;
    int   lat;
    logic got_done;
    logic [2:0] res_cnt;
    logic       res_inc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preset_mem(input logic [15:0] v);
        @(negedge clock);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clock);
        preset_en  = 1'b0;
    endtask

    // The start request is sampled at the first posedge; that cycle is cycle 0.
    // Unless hold=1, inputs are scrambled right after sampling to show they are latched.
    task automatic run_op(input logic [3:0] m, input logic [3:0] p, input bit hold);
        base      = wr_slot.size();
        done_base = done_cnt;
        @(negedge clock);
        registra_tiro_especial = 1'b1;
        mascara_direcoes       = m;
        posicao_nave           = p;
        @(posedge clock);
        got_done = 1'b0;
        lat      = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (c == 1 && !hold) begin
                registra_tiro_especial = 1'b0;
                mascara_direcoes       = ~m;
                posicao_nave           = ~p;
            end
            if (especial_registrado) begin
                got_done = 1'b1;
                lat      = c;
                res_cnt  = tiros_registrados;
                res_inc  = especial_incompleto;
                registra_tiro_especial = 1'b0;
                break;
            end
        end
        chk("done_seen", got_done, 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_wr(input int idx, input int slot, input int op, input int pos);
        chk($sformatf("wr%0d_slot", idx), wr_slot[base+idx], slot);
        chk($sformatf("wr%0d_op", idx),   wr_op[base+idx], op);
        chk($sformatf("wr%0d_pos", idx),  wr_pos[base+idx], pos);
        chk($sformatf("wr%0d_load", idx), wr_ld[base+idx], 1);
    endtask

    int n_wr;
    int wait_cnt;

    initial begin
        reset                  = 1'b1;
        registra_tiro_especial = 1'b0;
        mascara_direcoes       = '0;
        posicao_nave           = '0;

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_estado", db_estado, 0);
        chk("rst_ocupado", ocupado, 1);
        chk("rst_wr", enable_mem_tiro, 0);
        chk("rst_ld", enable_load_tiro, 0);
        chk("rst_done", especial_registrado, 0);
        chk("rst_inc", especial_incompleto, 0);
        chk("rst_addr", endereco_tiro, 0);
        chk("rst_pos", dado_posicao, 0);
        chk("rst_op", dado_opcode, 0);
        chk("rst_cnt", tiros_registrados, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_estado", db_estado, 1);
        chk("idle_ocupado", ocupado, 0);

        // Empty memory, all four directions, position 5
        preset_mem(16'h0000);
        run_op(4'b1111, 4'd5, 1'b0);
        chk("t1_latency", lat, 19);
        chk("t1_count", res_cnt, 4);
        chk("t1_inc", res_inc, 0);
        n_wr = wr_slot.size() - base;
        chk("t1_nwrites", n_wr, 4);
        if (n_wr == 4) begin
            for (int i = 0; i < 4; i++) chk_wr(i, i, i, 5);
        end

        // Slots 0 and 2 occupied, mask 0101
        preset_mem(16'h0005);
        run_op(4'b0101, 4'd9, 1'b0);
        chk("t2_count", res_cnt, 2);
        chk("t2_inc", res_inc, 0);
        n_wr = wr_slot.size() - base;
        chk("t2_nwrites", n_wr, 2);
        if (n_wr == 2) begin
            chk_wr(0, 1, 0, 9);
            chk_wr(1, 3, 2, 9);
        end

        // Slots 0..13 occupied: memory runs out after two shots
        preset_mem(16'h3FFF);
        run_op(4'b1111, 4'd2, 1'b0);
        chk("t3_count", res_cnt, 2);
        chk("t3_inc", res_inc, 1);
        n_wr = wr_slot.size() - base;
        chk("t3_nwrites", n_wr, 2);
        if (n_wr == 2) begin
            chk_wr(0, 14, 0, 2);
            chk_wr(1, 15, 1, 2);
        end

        // Count holds while idle
        repeat (5) @(negedge clock);
        chk("hold_estado", db_estado, 1);
        chk("hold_count", tiros_registrados, 2);

        // Last shot lands in slot 15, nothing left over
        preset_mem(16'h7FFF);
        run_op(4'b0010, 4'd7, 1'b0);
        chk("t4_count", res_cnt, 1);
        chk("t4_inc", res_inc, 0);
        n_wr = wr_slot.size() - base;
        chk("t4_nwrites", n_wr, 1);
        if (n_wr == 1) chk_wr(0, 15, 1, 7);

        // Zero mask, start held high throughout
        preset_mem(16'h0000);
        run_op(4'b0000, 4'd3, 1'b1);
        chk("t5_count", res_cnt, 0);
        chk("t5_inc", res_inc, 0);
        chk("t5_nwrites", wr_slot.size() - base, 0);
        chk("t5_done_pulses", done_cnt - done_base, 1);
        chk("t5_idle", db_estado, 1);

        // Reset asserted while in SALVA
        preset_mem(16'h0000);
        @(negedge clock);
        registra_tiro_especial = 1'b1;
        mascara_direcoes       = 4'b0001;
        posicao_nave           = 4'd6;
        @(negedge clock);
        registra_tiro_especial = 1'b0;
        wait_cnt = 0;
        while (db_estado != 4'd5 && wait_cnt < 50) begin
            @(negedge clock);
            wait_cnt++;
        end
        chk("t6_reached_salva", db_estado, 5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_rst_estado", db_estado, 0);
        chk("t6_rst_wr", enable_mem_tiro, 0);
        chk("t6_rst_ld", enable_load_tiro, 0);
        chk("t6_rst_cnt", tiros_registrados, 0);
        @(negedge clock);
        chk("t6_after_estado", db_estado, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
